// File: rtl/synth_pkg.sv
// Shared constants and helpers for the multi-voice square-wave synthesiser:
// width derivation, minimum half-period and the power-on note table.
package synth_pkg;

  localparam int MIN_PERIOD     = 2;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_NUM_NOTES  = 8;
  localparam int DEF_VOL_W      = 4;

  localparam int IDX_W = $clog2(DEF_NUM_NOTES);
  localparam int MIX_W = DEF_VOL_W + $clog2(DEF_NUM_VOICES) + 1;

  function automatic int calc_idx_w(input int num_notes);
    if (num_notes > 1) begin
      return $clog2(num_notes);
    end else begin
      return 1;
    end
  endfunction

  function automatic int calc_mix_w(input int num_voices, input int vol_w);
    return vol_w + $clog2(num_voices) + 1;
  endfunction

  // Entry i halves the base half-period i times, floored at the minimum period.
  function automatic logic [31:0] default_period(input int idx);
    logic [31:0] v;
    v = 32'd13514 >> idx;
    if (v < 32'(MIN_PERIOD)) begin
      v = 32'(MIN_PERIOD);
    end
    return v;
  endfunction

endpackage

// File: rtl/synth_voice.sv
// One tone voice: half-period counter with glitch-free note switching,
// square-wave toggle and a saturating attack/release envelope.
module synth_voice
  import synth_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int VOL_W    = 4,
  parameter int NOTE_W   = IDX_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_gate,
  input  logic                i_tick,
  input  logic [NOTE_W-1:0]   i_note,
  output logic [NOTE_W-1:0]   o_idx,
  output logic [VOL_W-1:0]    o_level,
  output logic                o_sq
);

  localparam logic [VOL_W-1:0] VOL_MAX = {VOL_W{1'b1}};

  logic [PERIOD_W-1:0] r_cnt;
  logic [NOTE_W-1:0]   r_idx;
  logic [VOL_W-1:0]    r_vol;
  logic                r_sq;
  logic [PERIOD_W-1:0] w_period;
  logic                w_wrap;

  // Clamp the period and detect the end of the half-period; the >= also
  // recovers at once when a table write shrinks the period below the count.
  always_comb begin
    w_period = i_period;
    if (i_period < PERIOD_W'(MIN_PERIOD)) begin
      w_period = PERIOD_W'(MIN_PERIOD);
    end else begin
      w_period = i_period;
    end
    w_wrap = (r_cnt >= (w_period - PERIOD_W'(1)));
  end

  // Half-period counter, square toggle and note latch at each toggle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
      r_idx <= i_note;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_sq  <= ~r_sq;
      r_idx <= i_note;
    end else begin
      r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

  // Envelope steps once per prescaler tick, saturating at both ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vol <= '0;
    end else if (i_tick) begin
      if (i_gate) begin
        if (r_vol != VOL_MAX) begin
          r_vol <= r_vol + VOL_W'(1);
        end
      end else if (r_vol != VOL_W'(0)) begin
        r_vol <= r_vol - VOL_W'(1);
      end
    end
  end

  assign o_idx   = r_idx;
  assign o_sq    = r_sq;
  assign o_level = r_sq ? r_vol : VOL_W'(0);

endmodule

// File: rtl/multi_voice_synth.sv
// Multi-voice square-wave synthesiser: shared note table and envelope
// prescaler, NUM_VOICES voices, registered mixer and 1-bit sigma-delta output.
module multi_voice_synth
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NUM_NOTES  = 8,
  parameter int PERIOD_W   = 16,
  parameter int VOL_W      = 4,
  parameter int ENV_DIV    = 1024
) (
  input  logic                                          CLK,
  input  logic                                          RST_N,
  input  logic                                          TBL_WE,
  input  logic [calc_idx_w(NUM_NOTES)-1:0]              TBL_ADDR,
  input  logic [PERIOD_W-1:0]                           TBL_DATA,
  input  logic [NUM_VOICES*calc_idx_w(NUM_NOTES)-1:0]   NOTE_SEL,
  input  logic [NUM_VOICES-1:0]                         GATE,
  output logic [NUM_VOICES-1:0]                         VOICE_SQ,
  output logic [calc_mix_w(NUM_VOICES, VOL_W)-1:0]      MIX,
  output logic                                          AUDIO
);

  localparam int NOTE_W = calc_idx_w(NUM_NOTES);
  localparam int SUM_W  = calc_mix_w(NUM_VOICES, VOL_W);
  localparam int PRE_W  = $clog2(ENV_DIV);

  logic [PERIOD_W-1:0] r_table [NUM_NOTES];
  logic [PRE_W-1:0]    r_pre;
  logic [SUM_W-1:0]    r_mix;
  logic [SUM_W:0]      r_acc;
  logic                w_tick;
  logic [SUM_W-1:0]    w_sum;
  logic [SUM_W:0]      w_sd;
  logic [NOTE_W-1:0]   w_idx    [NUM_VOICES];
  logic [VOL_W-1:0]    w_level  [NUM_VOICES];
  logic [PERIOD_W-1:0] w_period [NUM_VOICES];

  // Note table: reset reloads the defaults, writes are synchronous.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        r_table[i] <= PERIOD_W'(default_period(i));
      end
    end else if (TBL_WE) begin
      r_table[TBL_ADDR] <= TBL_DATA;
    end
  end

  assign w_tick = (r_pre == PRE_W'(ENV_DIV - 1));

  // Envelope prescaler, wraps every ENV_DIV clocks.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign w_period[v] = r_table[w_idx[v]];

    synth_voice #(
      .PERIOD_W (PERIOD_W),
      .VOL_W    (VOL_W),
      .NOTE_W   (NOTE_W)
    ) u_voice (
      .i_clk    (CLK),
      .i_rst_n  (RST_N),
      .i_period (w_period[v]),
      .i_gate   (GATE[v]),
      .i_tick   (w_tick),
      .i_note   (NOTE_SEL[v*NOTE_W +: NOTE_W]),
      .o_idx    (w_idx[v]),
      .o_level  (w_level[v]),
      .o_sq     (VOICE_SQ[v])
    );
  end

  // Sum of the per-voice levels; the width covers every voice at full scale.
  always_comb begin
    w_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_sum = w_sum + SUM_W'(w_level[v]);
    end
  end

  assign w_sd = {1'b0, r_acc[SUM_W-1:0]} + {1'b0, r_mix};

  // Mixer register and sigma-delta accumulator; the stored carry is AUDIO.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mix <= '0;
      r_acc <= '0;
    end else begin
      r_mix <= w_sum;
      r_acc <= w_sd;
    end
  end

  assign MIX   = r_mix;
  assign AUDIO = r_acc[SUM_W];

endmodule

// File: tb/tb_multi_voice_synth.sv
// Directed bench for multi_voice_synth: note timing, glitch-free note change,
// envelope, mixer/sigma-delta, period clamp and asynchronous reset.
module tb_multi_voice_synth;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        TBL_WE = 1'b0;
  logic [2:0]  TBL_ADDR = 3'd0;
  logic [15:0] TBL_DATA = 16'd0;
  logic [11:0] NOTE_SEL = 12'd0;
  logic [3:0]  GATE = 4'd0;
  logic [3:0]  VOICE_SQ;
  logic [6:0]  MIX;
  logic        AUDIO;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multi_voice_synth #(
    .NUM_VOICES (4),
    .NUM_NOTES  (8),
    .PERIOD_W   (16),
    .VOL_W      (4),
    .ENV_DIV    (4)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .TBL_WE   (TBL_WE),
    .TBL_ADDR (TBL_ADDR),
    .TBL_DATA (TBL_DATA),
    .NOTE_SEL (NOTE_SEL),
    .GATE     (GATE),
    .VOICE_SQ (VOICE_SQ),
    .MIX      (MIX),
    .AUDIO    (AUDIO)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ns4(input int a, input int b, input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic hold_reset(input logic [11:0] ns, input logic [3:0] g);
    RST_N    = 1'b0;
    TBL_WE   = 1'b0;
    NOTE_SEL = ns;
    GATE     = g;
    repeat (3) @(negedge CLK);
  endtask

  // Number of clock edges until VOICE_SQ[v] changes, or -1 if the budget expires.
  task automatic wait_toggle(input int v, input int budget, output int n);
    logic s;
    s = VOICE_SQ[v];
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge CLK);
      if (VOICE_SQ[v] !== s) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int t1;
    int ones;

    hold_reset(ns4(0, 0, 0, 0), 4'b0000);
    check("rst_voice_sq", VOICE_SQ, 0);
    check("rst_mix", MIX, 0);
    check("rst_audio", AUDIO, 0);

    // Default note 0 half-period is 13514 clocks.
    RST_N = 1'b1;
    wait_toggle(0, 14000, n);
    check("note0_first_toggle", n, 13514);

    // Voice 1 on rewritten note 1, switched to note 2 mid-period.
    hold_reset(ns4(0, 1, 0, 0), 4'b0000);
    RST_N = 1'b1; TBL_WE = 1'b1; TBL_ADDR = 3'd1; TBL_DATA = 16'd100;
    t1 = -1;
    for (int e = 1; e <= 200; e++) begin
      @(negedge CLK);
      if (e == 1) TBL_WE = 1'b0;
      if (e == 30) NOTE_SEL[5:3] = 3'd2;
      if (t1 < 0 && VOICE_SQ[1] === 1'b1) t1 = e;
    end
    check("v1_first_toggle", t1, 100);
    wait_toggle(1, 4000, n);
    check("v1_switch_to_note2", n, 3378 - 100);

    // Voice 0 forced high at edge 2, then envelope rise/hold/decay with ENV_DIV=4.
    hold_reset(ns4(1, 0, 0, 0), 4'b0001);
    RST_N = 1'b1; NOTE_SEL = ns4(0, 0, 0, 0);
    TBL_WE = 1'b1; TBL_ADDR = 3'd1; TBL_DATA = 16'd2;
    for (int e = 1; e <= 160; e++) begin
      @(negedge CLK);
      if (e == 1) TBL_WE = 1'b0;
      if (e == 80) GATE = 4'b0000;
      if (e == 2)   check("env_sq_high", VOICE_SQ, 1);
      if (e == 5)   check("env_mix_e5", MIX, 1);
      if (e == 60)  check("env_mix_e60", MIX, 14);
      if (e == 61)  check("env_mix_e61", MIX, 15);
      if (e == 84)  check("env_hold_e84", MIX, 15);
      if (e == 85)  check("env_decay_e85", MIX, 14);
      if (e == 140) check("env_decay_e140", MIX, 1);
      if (e == 141) check("env_floor_e141", MIX, 0);
      if (e == 160) check("env_floor_e160", MIX, 0);
    end

    // All four voices high and at full volume.
    hold_reset(ns4(1, 1, 1, 1), 4'b1111);
    RST_N = 1'b1; NOTE_SEL = ns4(0, 0, 0, 0);
    TBL_WE = 1'b1; TBL_ADDR = 3'd1; TBL_DATA = 16'd2;
    for (int e = 1; e <= 61; e++) begin
      @(negedge CLK);
      if (e == 1) TBL_WE = 1'b0;
      if (e == 3)  check("mix4_e3", MIX, 0);
      if (e == 5)  check("mix4_e5", MIX, 4);
      if (e == 60) check("mix4_e60", MIX, 56);
      if (e == 61) check("mix4_full", MIX, 60);
      if (e == 61) check("mix4_sq_all", VOICE_SQ, 15);
    end
    ones = 0;
    for (int i = 0; i < 128; i++) begin
      @(negedge CLK);
      ones += int'(AUDIO);
    end
    check("audio_density_ok", int'(ones >= 59 && ones <= 61), 1);

    // Asynchronous reset mid-cycle with outputs active.
    check("pre_rst_mix", MIX, 60);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_sq", VOICE_SQ, 0);
    check("async_rst_mix", MIX, 0);
    check("async_rst_audio", AUDIO, 0);
    NOTE_SEL = ns4(0, 1, 0, 0);
    GATE = 4'b0000;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    wait_toggle(1, 7000, n);
    check("table_reloaded_note1", n, 6757);

    // Period clamp: table entries 0 and 1 behave as 2.
    TBL_WE = 1'b1; TBL_ADDR = 3'd0; TBL_DATA = 16'd0;
    @(negedge CLK);
    TBL_WE = 1'b0;
    wait_toggle(0, 20, n);
    check("clamp0_alive", int'(n > 0), 1);
    wait_toggle(0, 20, n);
    check("clamp0_interval_a", n, 2);
    wait_toggle(0, 20, n);
    check("clamp0_interval_b", n, 2);
    TBL_WE = 1'b1; TBL_ADDR = 3'd0; TBL_DATA = 16'd1;
    @(negedge CLK);
    TBL_WE = 1'b0;
    wait_toggle(0, 20, n);
    check("clamp1_alive", int'(n > 0), 1);
    wait_toggle(0, 20, n);
    check("clamp1_interval_a", n, 2);
    wait_toggle(0, 20, n);
    check("clamp1_interval_b", n, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
